// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: word, RAM state, arbiter FSM state
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arbstate_t;

    localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - RAM-side bus between the memory arbiter and the RAM model
interface mem_arb_if
    import cpu_types_pkg::*;
;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport arb (output ramREN, ramWEN, ramaddr, ramstore, input ramload, ramstate);
    modport ram (input ramREN, ramWEN, ramaddr, ramstore, output ramload, ramstate);
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D arbiter for a single-port RAM with timeout and sticky bus error
// MEM_ARB_ROUND_ROBIN_EN selects round-robin contention; otherwise data has fixed priority.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic   CLK,
    input  logic   nRST,
    input  logic   iREN,
    input  word_t  iaddr,
    output word_t  iload,
    output logic   iwait,
    input  logic   dREN,
    input  logic   dWEN,
    input  word_t  daddr,
    input  word_t  dstore,
    output word_t  dload,
    output logic   dwait,
    output logic   bus_err,
    mem_arb_if.arb ram_bus
);

    localparam logic [ARB_CNT_W-1:0] CNT_LIM = ARB_CNT_W'(TIMEOUT - 1);

    arbstate_t            state, state_n;
    logic [ARB_CNT_W-1:0] cnt, cnt_n;
    logic                 err_set;
    logic                 d_req, d_first, pick_d, gnt_req;
    logic                 i_done, d_done;

    assign d_req   = dREN | dWEN;
    assign pick_d  = d_req & (~iREN | d_first);
    assign gnt_req = (state == GNT_I) ? iREN : d_req;
    assign i_done  = (state == GNT_I) && (ram_bus.ramstate == ACCESS);
    assign d_done  = (state == GNT_D) && (ram_bus.ramstate == ACCESS);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_gnt: 1 = data was granted last, so instruction wins the next tie
    logic last_gnt;
    assign d_first = ~last_gnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            last_gnt <= 1'b0;
        else if (state == IDLE && (iREN || d_req))
            last_gnt <= pick_d;
    end
`else
    assign d_first = 1'b1;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (iREN || d_req) begin
                    cnt_n   = '0;
                    state_n = pick_d ? GNT_D : GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (!gnt_req || ram_bus.ramstate == ACCESS) begin
                    state_n = IDLE;
                end else if (ram_bus.ramstate == ERROR) begin
                    err_set = 1'b1;
                    state_n = IDLE;
                end else begin
                    if (cnt != '1)
                        cnt_n = cnt + 1'b1;
                    if (cnt == CNT_LIM) begin
                        err_set = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (err_set)
                bus_err <= 1'b1;
        end
    end

    // RAM enables follow the live request so a withdrawn request drops them at once
    always_comb begin
        ram_bus.ramREN   = 1'b0;
        ram_bus.ramWEN   = 1'b0;
        ram_bus.ramaddr  = '0;
        ram_bus.ramstore = '0;
        case (state)
            GNT_I: begin
                ram_bus.ramREN  = iREN;
                ram_bus.ramaddr = iaddr;
            end
            GNT_D: begin
                ram_bus.ramWEN   = dWEN;
                ram_bus.ramREN   = dREN & ~dWEN;
                ram_bus.ramaddr  = daddr;
                ram_bus.ramstore = dstore;
            end
            default: ;
        endcase
    end

    assign iwait = iREN & ~i_done;
    assign dwait = d_req & ~d_done;
    assign iload = i_done ? ram_bus.ramload : '0;
    assign dload = d_done ? ram_bus.ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (TIMEOUT=4)
`timescale 1ns/1ps
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic  CLK;
    logic  nRST;
    logic  iREN, dREN, dWEN;
    word_t iaddr, daddr, dstore;
    word_t iload, dload;
    logic  iwait, dwait, bus_err;
    int    checks = 0;
    int    errors = 0;
    logic  rr;
    logic  exp_d;

    mem_arb_if ram_bus ();

    mem_arbiter #(.TIMEOUT(4)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iload   (iload),
        .iwait   (iwait),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dload   (dload),
        .dwait   (dwait),
        .bus_err (bus_err),
        .ram_bus (ram_bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
        ram_bus.ramload  = '0;
        ram_bus.ramstate = FREE;
        #2;
        check("rst_ramREN", ram_bus.ramREN, 0);
        check("rst_ramWEN", ram_bus.ramWEN, 0);
        check("rst_ramaddr", ram_bus.ramaddr, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_iwait_idle", iwait, 0);
        check("rst_dwait_idle", dwait, 0);
        iREN = 1; dREN = 1; settle();
        check("rst_iwait_follow", iwait, 1);
        check("rst_dwait_follow", dwait, 1);
        check("rst_iload", iload, 0);
        iREN = 0; dREN = 0;
        tick();
        nRST = 1'b1;

        // instruction read, ACCESS on 3rd granted cycle
        iREN = 1; iaddr = 32'h40; ram_bus.ramstate = BUSY; settle();
        check("t1_idle_ramREN", ram_bus.ramREN, 0);
        check("t1_idle_iwait", iwait, 1);
        tick();
        check("t1_g1_ramREN", ram_bus.ramREN, 1);
        check("t1_g1_ramaddr", ram_bus.ramaddr, 32'h40);
        check("t1_g1_iwait", iwait, 1);
        tick();
        check("t1_g2_ramREN", ram_bus.ramREN, 1);
        check("t1_g2_iload", iload, 0);
        tick();
        ram_bus.ramstate = ACCESS; ram_bus.ramload = 32'hDEADBEEF; settle();
        check("t1_g3_ramREN", ram_bus.ramREN, 1);
        check("t1_g3_iwait", iwait, 0);
        check("t1_g3_iload", iload, 32'hDEADBEEF);
        tick();
        iREN = 0; ram_bus.ramstate = FREE; settle();
        check("t1_done_ramREN", ram_bus.ramREN, 0);
        check("t1_done_iwait", iwait, 0);
        check("t1_done_iload", iload, 0);

        // simultaneous instruction read and data write
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        ram_bus.ramstate = BUSY; settle();
        check("t2_idle_ramWEN", ram_bus.ramWEN, 0);
        tick();
        ram_bus.ramstate = ACCESS; settle();
        check("t2_d_ramWEN", ram_bus.ramWEN, 1);
        check("t2_d_ramREN", ram_bus.ramREN, 0);
        check("t2_d_ramaddr", ram_bus.ramaddr, 32'h80);
        check("t2_d_ramstore", ram_bus.ramstore, 32'h1234);
        check("t2_d_dwait", dwait, 0);
        check("t2_d_iwait", iwait, 1);
        tick();
        dWEN = 0; dREN = 1; daddr = 32'h84; ram_bus.ramstate = BUSY; settle();
        check("t2_idle_ramaddr", ram_bus.ramaddr, 0);
        check("t2_idle_ramstore", ram_bus.ramstore, 0);
        tick();
        ram_bus.ramstate = ACCESS; ram_bus.ramload = 32'h11111111; settle();
        check("t2_second_ramaddr", ram_bus.ramaddr, rr ? 32'h44 : 32'h84);
        check("t2_second_iwait", iwait, rr ? 0 : 1);
        check("t2_second_dwait", dwait, rr ? 1 : 0);
        check("t2_second_iload", iload, rr ? 32'h11111111 : 32'h0);
        check("t2_second_dload", dload, rr ? 32'h0 : 32'h11111111);
        tick();
        iREN = 0; dREN = 0; ram_bus.ramstate = FREE; settle();
        check("t2_end_ramREN", ram_bus.ramREN, 0);

        // back-to-back contention from a fresh reset
        nRST = 0; settle(); nRST = 1;
        iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h100;
        ram_bus.ramstate = ACCESS; ram_bus.ramload = 32'h0000ABCD; settle();
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_d = rr ? (k % 2 == 0) : 1'b1;
            check($sformatf("t3_grant%0d_ramaddr", k), ram_bus.ramaddr, exp_d ? 32'h100 : 32'h200);
            check($sformatf("t3_grant%0d_dwait", k), dwait, exp_d ? 0 : 1);
            check($sformatf("t3_grant%0d_iwait", k), iwait, exp_d ? 1 : 0);
            tick();
            check($sformatf("t3_idle%0d_ramREN", k), ram_bus.ramREN, 0);
        end

        // data request withdrawn while granted and BUSY
        iaddr = 32'h48; daddr = 32'h90; ram_bus.ramstate = BUSY;
        tick();
        check("t4_gd_ramaddr", ram_bus.ramaddr, 32'h90);
        dREN = 0; settle();
        check("t4_withdraw_ramREN", ram_bus.ramREN, 0);
        check("t4_withdraw_dwait", dwait, 0);
        tick();
        check("t4_idle_ramREN", ram_bus.ramREN, 0);
        check("t4_idle_ramaddr", ram_bus.ramaddr, 0);
        check("t4_idle_iwait", iwait, 1);
        tick();
        check("t4_gi_ramREN", ram_bus.ramREN, 1);
        check("t4_gi_ramaddr", ram_bus.ramaddr, 32'h48);
        iREN = 0;
        tick();

        // timeout with RAM stuck BUSY
        dREN = 1; daddr = 32'hA0; settle();
        for (int g = 1; g <= 4; g++) begin
            tick();
            check($sformatf("t5_g%0d_ramREN", g), ram_bus.ramREN, 1);
            check($sformatf("t5_g%0d_bus_err", g), bus_err, 0);
        end
        tick();
        check("t5_to_bus_err", bus_err, 1);
        check("t5_to_ramREN", ram_bus.ramREN, 0);
        check("t5_to_dwait", dwait, 1);
        tick();
        check("t5_regrant_ramaddr", ram_bus.ramaddr, 32'hA0);
        ram_bus.ramstate = ACCESS; ram_bus.ramload = 32'hCAFEF00D; settle();
        check("t5_done_dwait", dwait, 0);
        check("t5_done_dload", dload, 32'hCAFEF00D);
        tick();
        dREN = 0; ram_bus.ramstate = FREE; settle();
        check("t5_sticky_bus_err", bus_err, 1);
        tick();
        check("t5_sticky2_bus_err", bus_err, 1);

        // RAM ERROR, then reset in the middle of a write
        nRST = 0; settle();
        check("t6_rst_bus_err", bus_err, 0);
        nRST = 1;
        dWEN = 1; daddr = 32'hB0; dstore = 32'h55; ram_bus.ramstate = BUSY; settle();
        check("t6_idle_ramWEN", ram_bus.ramWEN, 0);
        tick();
        ram_bus.ramstate = ERROR; settle();
        check("t6_err_ramWEN", ram_bus.ramWEN, 1);
        check("t6_err_dwait", dwait, 1);
        check("t6_err_dload", dload, 0);
        tick();
        ram_bus.ramstate = BUSY; settle();
        check("t6_after_bus_err", bus_err, 1);
        check("t6_after_ramWEN", ram_bus.ramWEN, 0);
        check("t6_after_dwait", dwait, 1);
        tick();
        check("t6_regrant_ramWEN", ram_bus.ramWEN, 1);
        check("t6_regrant_ramstore", ram_bus.ramstore, 32'h55);
        nRST = 0; settle();
        check("t6_midrst_ramWEN", ram_bus.ramWEN, 0);
        check("t6_midrst_ramaddr", ram_bus.ramaddr, 0);
        check("t6_midrst_ramstore", ram_bus.ramstore, 0);
        check("t6_midrst_bus_err", bus_err, 0);
        nRST = 1; settle();
        check("t6_postrst_idle_ramWEN", ram_bus.ramWEN, 0);
        tick();
        check("t6_reissue_ramWEN", ram_bus.ramWEN, 1);
        check("t6_reissue_ramaddr", ram_bus.ramaddr, 32'hB0);
        dWEN = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
